// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider with valid/ready
// handshakes on both sides, divide-by-zero detection and output backpressure.
// One quotient bit is resolved per clock.
// Optional feature: define DIV_SIGNED_EN for two's complement operands and
// results (truncating division). With the macro undefined the block is
// purely unsigned.

module seq_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH:0]   prem;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             neg;
    logic [WIDTH:0]   next_prem;
    logic [WIDTH-1:0] next_quo;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             accept;
    logic             last_iter;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_iter = (state == CALC) && (cnt == CNT_W'(1));

    // One restoring step: shift in the next dividend bit, trial subtract, restore on borrow
    always_comb begin
        shifted   = {prem, quo_r[WIDTH-1]};
        neg       = (shifted < {2'b00, dvs_r});
        diff      = shifted[WIDTH:0] - {1'b0, dvs_r};
        next_prem = neg ? shifted[WIDTH:0] : diff;
        next_quo  = {quo_r[WIDTH-2:0], ~neg};
`ifdef DIV_SIGNED_EN
        op_a  = dividend[WIDTH-1] ? -dividend : dividend;
        op_b  = divisor[WIDTH-1]  ? -divisor  : divisor;
        res_q = neg_q ? -next_quo : next_quo;
        res_r = neg_r ? -next_prem[WIDTH-1:0] : next_prem[WIDTH-1:0];
`else
        op_a  = dividend;
        op_b  = divisor;
        res_q = next_quo;
        res_r = next_prem[WIDTH-1:0];
`endif
    end

    // Control FSM plus the working registers of the iterative core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            quo_r <= '0;
            dvs_r <= '0;
            prem  <= '0;
            cnt   <= '0;
`ifdef DIV_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        quo_r <= op_a;
                        dvs_r <= op_b;
                        prem  <= '0;
                        cnt   <= CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
                        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r <= dividend[WIDTH-1];
`endif
                        state <= (divisor == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    quo_r <= next_quo;
                    prem  <= next_prem;
                    cnt   <= cnt - CNT_W'(1);
                    if (last_iter) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result registers change only on entry to DONE and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && (divisor == '0)) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (last_iter) begin
            quotient    <= res_q;
            remainder   <= res_r;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed test of seq_divider (WIDTH=8). Stimulus pushes the
// hand-computed result into a scoreboard queue; an independent monitor pops
// and compares on every output handshake. Latency, throughput, backpressure
// and mid-operation reset are checked directly by the stimulus process.
// Signed vectors are included when DIV_SIGNED_EN is defined.

module tb_seq_divider;

    localparam int WIDTH = 8;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used to timestamp accepts
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present one operand pair and wait for it to be accepted; optionally queue its result
    task automatic applyStimulus(input string name, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] eq, input logic [7:0] er, input logic ez,
                                 input bit push, output int acc_cycle);
        int guard;
        exp_t e;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_in_ready_timeout: got 0, expected 1", name);
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        acc_cycle = cyc_cnt;
        if (push) begin
            e.name = name;
            e.q = eq;
            e.r = er;
            e.z = ez;
            sb.push_back(e);
        end
    endtask

    // Count cycles from the accept edge until out_valid; optionally inject ignored operands
    task automatic waitValid(input bit noise, output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            if (noise && lat == 3) begin
                dividend = 8'd9;
                divisor  = 8'd3;
                in_valid = 1'b1;
            end
            if (lat == 6) in_valid = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare every result handshake against the queue head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got q=%0h r=%0h, expected no output", quotient, remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_q"}, quotient, e.q);
                checkOutput({e.name, "_r"}, remainder, e.r);
                checkOutput({e.name, "_dbz"}, div_by_zero, e.z);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc0, acc1, lat, guard;
        logic [7:0] exp_q, exp_r;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dbz", div_by_zero, 0);
        checkOutput("rst_q", quotient, 0);
        checkOutput("rst_r", remainder, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] 100/7 with ignored operands during CALC");
        applyStimulus("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1, acc0);
        checkOutput("calc_busy", busy, 1);
        checkOutput("calc_in_ready", in_ready, 0);
        waitValid(1'b1, lat);
        checkOutput("lat_100_7", lat, 9);
        @(posedge clk);
        #1;
        checkOutput("after_in_ready", in_ready, 1);
        checkOutput("after_out_valid", out_valid, 0);

        $display("[TB] back-to-back 255/1 then 3/200");
        applyStimulus("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1, acc0);
        applyStimulus("d3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 1'b1, acc1);
        checkOutput("throughput", acc1 - acc0, 10);
        waitValid(1'b0, lat);
        checkOutput("lat_3_200", lat, 9);

        $display("[TB] divide by zero 5/0");
        applyStimulus("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b1, acc0);
        waitValid(1'b0, lat);
        checkOutput("lat_5_0", lat, 1);
        @(posedge clk);
        #1;
        checkOutput("dbz_in_ready", in_ready, 1);

        $display("[TB] max/max 255/255");
        applyStimulus("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b1, acc0);
        waitValid(1'b0, lat);
        checkOutput("lat_255_255", lat, 9);

        $display("[TB] 200/9 under backpressure");
`ifdef DIV_SIGNED_EN
        exp_q = 8'hFA;
        exp_r = 8'hFE;
`else
        exp_q = 8'd22;
        exp_r = 8'd2;
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus("d200_9", 8'd200, 8'd9, exp_q, exp_r, 1'b0, 1'b1, acc0);
        waitValid(1'b0, lat);
        checkOutput("lat_200_9", lat, 9);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_q", quotient, exp_q);
            checkOutput("bp_r", remainder, exp_r);
            checkOutput("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", out_valid, 0);
        checkOutput("bp_release_ready", in_ready, 1);

        $display("[TB] reset during CALC");
        applyStimulus("d77_3", 8'd77, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0, acc0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_q", quotient, 0);
        checkOutput("abort_r", remainder, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("d50_5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b1, acc0);
        waitValid(1'b0, lat);
        checkOutput("lat_50_5", lat, 9);

`ifdef DIV_SIGNED_EN
        $display("[TB] signed vectors");
        @(posedge clk);
        #1;
        applyStimulus("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b1, acc0);
        waitValid(1'b0, lat);
        checkOutput("lat_m7_2", lat, 9);
        @(posedge clk);
        #1;
        applyStimulus("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, acc0);
        waitValid(1'b0, lat);
        checkOutput("lat_m128_m1", lat, 9);
`endif

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
